musb_scoreboard_hazard_unit: RTL
================================

Name: musb_scoreboard_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the MUSB pipeline.
- Extends match-based forwarding to an arbitrary number of producer stages.
- Adds a register scoreboard for long-latency writers (non-blocking loads, mul/div) that complete out of band.
- Sits beside the ID stage. Drives ID operand-forward selectors and the per-stage stall chain. Keeps a stall-cycle performance counter.

Parameters:
- GPR_AW, 5, GPR address width; the scoreboard tracks 2**GPR_AW registers, with register 0 never tracked.
- NSTAGE, 3, number of forwarding producer stages; index 0 is youngest (EX), NSTAGE-1 is oldest (WB).
- SB_DEPTH, 4, maximum number of outstanding long-latency writes.
- SW, $clog2(NSTAGE+1), forward selector width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_rs  in  GPR_AW  rs at ID.
- id_rt  in  GPR_AW  rt at ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- id_issue  in  1  valid instruction at ID, ready to advance.
- id_flush  in  1  ID instruction is being killed this cycle.
- id_long  in  1  ID instruction is a long-latency writer.
- id_wa  in  GPR_AW  destination of the ID instruction.
- st_wa  in  NSTAGE*GPR_AW  packed write addresses of producer stages.
- st_we  in  NSTAGE  producer write enables.
- st_ready  in  NSTAGE  producer result is available for forwarding.
- lu_done  in  1  long-latency unit completes and writes the GPR file this cycle.
- lu_done_wa  in  GPR_AW  register written by lu_done.
- if_stall_req  in  1  fetch-side stall request.
- ex_stall_req  in  1  EX unit stall request.
- mem_stall_req  in  1  LSU/MEM stall request.
- fwd_id_rs  out  SW  rs selector: 0 = GPR file, k = stage k-1.
- fwd_id_rt  out  SW  rt selector, same encoding.
- if_stall  out  1  stall for the IF stage.
- id_stall  out  1  stall for the ID stage.
- ex_stall  out  1  stall for the EX stage.
- mem_stall  out  1  stall for the MEM stage.
- wb_stall  out  1  stall for the WB stage.
- sb_full  out  1  outstanding count equals SB_DEPTH.
- sb_err  out  1  sticky flag: completion seen for a non-pending register.
- stall_cnt  out  32  hazard-stall cycle counter, saturating.

Behaviour:
- Reset (rst=0, async): pending vector=0, count=0, stall_cnt=0, sb_err=0. All outputs are combinational from these, so after reset sb_full=0.
- Match rule: match_k(r) = (r!=0) & st_we[k] & (st_wa[k]==r).
  - For each used operand, pick the smallest matching k.
  - If st_ready[k]=1: selector = k+1.
  - If st_ready[k]=0: raw hazard.
  - If no stage matches: selector = 0.
  - Unused operand: selector = 0, no hazard.
- Scoreboard hazard: operand used, no stage match, and pending[r]=1.
  - Exception: lu_done & lu_done_wa==r in the same cycle. The GPR file is write-first, so selector=0 and no stall.
- Structural/WAW block: id_issue & id_long & id_wa!=0, and either:
  - count==SB_DEPTH with no same-cycle lu_done, or
  - pending[id_wa]=1 not cleared this cycle.
- hz = (raw or scoreboard hazard or WAW block) & id_issue & ~id_flush.
- Stall chain (combinational):
  - mem_stall = mem_stall_req
  - wb_stall = mem_stall
  - ex_stall = mem_stall | ex_stall_req
  - id_stall = ex_stall | hz
  - if_stall = if_stall_req (no id_stall feedback, avoids loops)
- Set: id_issue & id_long & id_wa!=0 & ~id_stall & ~id_flush, then pending[id_wa]<=1 and count+1.
- Clear: lu_done & pending[lu_done_wa], then pending<=0 and count-1.
  - lu_done on a non-pending register (or register 0): no state change, sb_err<=1 until reset.
- Simultaneous set and clear:
  - Same register: pending stays 1, count unchanged.
  - Different registers: both apply, count unchanged.
- count never exceeds SB_DEPTH or drops below 0; the set is blocked when full.
- stall_cnt increments on every cycle hz=1, whether or not ex_stall is also high. It saturates at 32'hFFFF_FFFF.
- One-cycle registered latency from issue/complete to scoreboard state. Selectors have zero latency.

Decomposition:
- Package musb_hazard_pkg holds:
  - FWD_RF=0 constant
  - the selector-width function
  - a forward_pick function (youngest-ready priority encoder over NSTAGE)
- Sub-module musb_scoreboard holds the pending vector, outstanding counter, sb_full and sb_err. Interface: set/set_wa, clr/clr_wa, query ports.
- Top-level musb_scoreboard_hazard_unit holds forwarding, stall chain and stall_cnt.

Test Plan:
- Stage 1 (MEM) writes r5, ready; ID reads rs=5 -> fwd_id_rs=2, id_stall=0. Add stage 0 writing r5, not ready -> id_stall=1, stall_cnt increments by 1.
- Issue long write to r8; next cycle ID reads r8 -> stall for 3 cycles. lu_done wa=8 in cycle 4 -> same-cycle release, fwd=0, id_stall=0, count back to 0.
- Issue 4 long writes to r1..r4 -> sb_full=1. Fifth long issue -> stalled. lu_done r2 in the same cycle -> issue accepted, count stays 4.
- Long issue to r7 while r7 is pending -> WAW stall. Then lu_done r7 -> issue proceeds, pending[7]=1.
- lu_done for non-pending r9 -> sb_err=1, count unchanged. Assert rst mid-operation with 3 pending -> all pending, count, sb_err and stall_cnt = 0 immediately.
- mem_stall_req=1 -> mem/wb/ex/id_stall=1, if_stall=0, stall_cnt unchanged. id_flush with an r0 read and a hazard present -> no hz, no scoreboard set.

Source files
------------

// File: rtl/musb_scoreboard_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// musb_hazard_pkg
// Shared types, constants and helper functions for the MUSB hazard /
// forwarding controller.
//   FWD_RF        : forward-selector value meaning "read the GPR file"
//   MAX_NSTAGE    : widest producer chain forward_pick can encode
//   fwd_pick_t    : result of the youngest-match priority encoder
//   sel_width()   : forward selector width for a given stage count
//   forward_pick(): youngest matching producer plus its ready flag
// ---------------------------------------------------------------------------
package musb_hazard_pkg;

    localparam int FWD_RF     = 0;
    localparam int MAX_NSTAGE = 16;

    typedef struct packed {
        logic       hit;
        logic       ready;
        logic [3:0] idx;
    } fwd_pick_t;

    // One selector code per producer stage plus the GPR-file code.
    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

    // Walks from oldest to youngest so the last hit written is the youngest
    // (lowest index) matching stage, which always holds the newest value.
    function automatic fwd_pick_t forward_pick(input logic [MAX_NSTAGE-1:0] match,
                                               input logic [MAX_NSTAGE-1:0] ready);
        fwd_pick_t p;
        p = '0;
        for (int k = MAX_NSTAGE - 1; k >= 0; k--) begin
            if (match[k]) begin
                p.hit   = 1'b1;
                p.ready = ready[k];
                p.idx   = 4'(k);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/musb_scoreboard_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// musb_hazard_if
// Bundles every pipeline-facing signal of the hazard unit.
//   master : pipeline side; drives ID/producer/completion/stall requests,
//            receives forward selectors, stall chain and status.
//   slave  : hazard unit side (the mirror image).
// Inputs to the unit : id_rs, id_rt, id_rs_used, id_rt_used, id_issue,
//   id_flush, id_long, id_wa, st_wa, st_we, st_ready, lu_done, lu_done_wa,
//   if_stall_req, ex_stall_req, mem_stall_req
// Outputs of the unit: fwd_id_rs, fwd_id_rt, if/id/ex/mem/wb_stall,
//   sb_full, sb_err, stall_cnt
// ---------------------------------------------------------------------------
interface musb_hazard_if #(
    parameter int GPR_AW = 5,
    parameter int NSTAGE = 3
) ();
    import musb_hazard_pkg::*;

    localparam int SW = sel_width(NSTAGE);

    logic [GPR_AW-1:0]        id_rs;
    logic [GPR_AW-1:0]        id_rt;
    logic                     id_rs_used;
    logic                     id_rt_used;
    logic                     id_issue;
    logic                     id_flush;
    logic                     id_long;
    logic [GPR_AW-1:0]        id_wa;
    logic [NSTAGE*GPR_AW-1:0] st_wa;
    logic [NSTAGE-1:0]        st_we;
    logic [NSTAGE-1:0]        st_ready;
    logic                     lu_done;
    logic [GPR_AW-1:0]        lu_done_wa;
    logic                     if_stall_req;
    logic                     ex_stall_req;
    logic                     mem_stall_req;

    logic [SW-1:0]            fwd_id_rs;
    logic [SW-1:0]            fwd_id_rt;
    logic                     if_stall;
    logic                     id_stall;
    logic                     ex_stall;
    logic                     mem_stall;
    logic                     wb_stall;
    logic                     sb_full;
    logic                     sb_err;
    logic [31:0]              stall_cnt;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_issue, id_flush,
               id_long, id_wa, st_wa, st_we, st_ready, lu_done, lu_done_wa,
               if_stall_req, ex_stall_req, mem_stall_req,
        input  fwd_id_rs, fwd_id_rt, if_stall, id_stall, ex_stall,
               mem_stall, wb_stall, sb_full, sb_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_issue, id_flush,
               id_long, id_wa, st_wa, st_we, st_ready, lu_done, lu_done_wa,
               if_stall_req, ex_stall_req, mem_stall_req,
        output fwd_id_rs, fwd_id_rt, if_stall, id_stall, ex_stall,
               mem_stall, wb_stall, sb_full, sb_err, stall_cnt
    );

endinterface

// File: rtl/musb_scoreboard_hazard_unit_scoreboard.sv
// ---------------------------------------------------------------------------
// musb_scoreboard
// Pending-write scoreboard for long-latency writers.
//   clk, rst      : clock, asynchronous active-low reset
//   set_i/set_wa_i: mark a register as having an outstanding write
//   clr_i/clr_wa_i: long-latency completion for a register
//   pending_o     : one bit per GPR, bit 0 is never set
//   clr_ok_o      : completion hits a pending register this cycle
//   sb_full_o     : outstanding count equals SB_DEPTH
//   sb_err_o      : sticky, completion seen for a non-pending register
// ---------------------------------------------------------------------------
module musb_scoreboard #(
    parameter int GPR_AW   = 5,
    parameter int SB_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_i,
    input  logic [GPR_AW-1:0]      set_wa_i,
    input  logic                   clr_i,
    input  logic [GPR_AW-1:0]      clr_wa_i,
    output logic [2**GPR_AW-1:0]   pending_o,
    output logic                   clr_ok_o,
    output logic                   sb_full_o,
    output logic                   sb_err_o
);

    localparam int NREG = 2**GPR_AW;
    localparam int CW   = $clog2(SB_DEPTH + 1);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            clr_ok;
    logic            clr_same;
    logic            set_ok;

    // A completion only retires something if the register is really pending.
    assign clr_ok   = clr_i & pending_q[clr_wa_i];
    assign clr_same = clr_ok & (clr_wa_i == set_wa_i);

    // Guard the set locally as well so the count can never leave
    // [0, SB_DEPTH] and a register is never double-counted, even if the
    // caller forgets to block the issue.
    assign set_ok = set_i & (set_wa_i != '0)
                  & (~pending_q[set_wa_i] | clr_same)
                  & ((count_q != CW'(SB_DEPTH)) | clr_ok);

    // Next-state: clear first, then set, so a same-register set and clear
    // leaves the bit high; the count moves only when exactly one applies.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q | (clr_i & ~pending_q[clr_wa_i]);
        if (clr_ok) begin
            pending_d[clr_wa_i] = 1'b0;
        end
        if (set_ok) begin
            pending_d[set_wa_i] = 1'b1;
        end
        case ({set_ok, clr_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign pending_o = pending_q;
    assign clr_ok_o  = clr_ok;
    assign sb_full_o = (count_q == CW'(SB_DEPTH));
    assign sb_err_o  = err_q;

endmodule

// File: rtl/musb_scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// musb_scoreboard_hazard_unit
// Hazard and forwarding controller beside the MUSB ID stage.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   hz_if : musb_hazard_if.slave carrying ID operands, producer-stage write
//           info, long-latency completions and stall requests in; forward
//           selectors, per-stage stalls, scoreboard status and the
//           hazard-stall cycle counter out.
// Forward selector encoding: 0 = GPR file, k = producer stage k-1.
// ---------------------------------------------------------------------------
module musb_scoreboard_hazard_unit
    import musb_hazard_pkg::*;
#(
    parameter int GPR_AW   = 5,
    parameter int NSTAGE   = 3,
    parameter int SB_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    musb_hazard_if.slave  hz_if
);

    localparam int SW   = sel_width(NSTAGE);
    localparam int NREG = 2**GPR_AW;

    logic [NREG-1:0] pending;
    logic            clr_ok;
    logic            sb_full;
    logic            sb_err;

    logic [SW-1:0]   op_sel [2];
    logic [1:0]      op_raw;
    logic [1:0]      op_sbh;

    logic            long_req;
    logic            waw_block;
    logic            hz;
    logic            ex_stall;
    logic            id_stall;
    logic            sb_set;

    logic [31:0]     stall_cnt_q, stall_cnt_d;

    // Per-operand forwarding: the youngest matching producer wins. A ready
    // producer is forwarded, a not-ready one is a RAW hazard. With no
    // producer match, a pending long-latency write is a scoreboard hazard
    // unless it completes this very cycle (the GPR file is write-first, so
    // reading the file already returns the new value).
    always_comb begin
        logic [GPR_AW-1:0]     r;
        logic                  used;
        logic [MAX_NSTAGE-1:0] match_v;
        logic [MAX_NSTAGE-1:0] ready_v;
        fwd_pick_t             pick;
        for (int o = 0; o < 2; o++) begin
            r       = (o == 0) ? hz_if.id_rs      : hz_if.id_rt;
            used    = (o == 0) ? hz_if.id_rs_used : hz_if.id_rt_used;
            match_v = '0;
            ready_v = '0;
            for (int k = 0; k < NSTAGE; k++) begin
                match_v[k] = (r != '0) & hz_if.st_we[k]
                           & (hz_if.st_wa[k*GPR_AW +: GPR_AW] == r);
                ready_v[k] = hz_if.st_ready[k];
            end
            pick      = forward_pick(match_v, ready_v);
            op_sel[o] = SW'(FWD_RF);
            op_raw[o] = 1'b0;
            op_sbh[o] = 1'b0;
            if (used) begin
                if (pick.hit) begin
                    if (pick.ready) begin
                        op_sel[o] = SW'(pick.idx) + SW'(1);
                    end else begin
                        op_raw[o] = 1'b1;
                    end
                end else if (pending[r] &&
                             !(hz_if.lu_done && (hz_if.lu_done_wa == r))) begin
                    op_sbh[o] = 1'b1;
                end
            end
        end
    end

    // A long-latency issue must wait when the scoreboard has no free slot
    // (unless a completion frees one this cycle) or when its destination
    // still has an outstanding write that is not retiring this cycle.
    always_comb begin
        long_req  = hz_if.id_issue & hz_if.id_long & (hz_if.id_wa != '0);
        waw_block = long_req &
                    ((sb_full & ~clr_ok) |
                     (pending[hz_if.id_wa] &
                      ~(clr_ok & (hz_if.lu_done_wa == hz_if.id_wa))));
        hz        = ((|op_raw) | (|op_sbh) | waw_block)
                  & hz_if.id_issue & ~hz_if.id_flush;
    end

    // Stall chain: older stages stall younger ones. Fetch is deliberately
    // not fed back from ID to keep the chain free of combinational loops.
    assign ex_stall = hz_if.mem_stall_req | hz_if.ex_stall_req;
    assign id_stall = ex_stall | hz;
    assign sb_set   = long_req & ~id_stall & ~hz_if.id_flush;

    musb_scoreboard #(
        .GPR_AW   (GPR_AW),
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_i     (sb_set),
        .set_wa_i  (hz_if.id_wa),
        .clr_i     (hz_if.lu_done),
        .clr_wa_i  (hz_if.lu_done_wa),
        .pending_o (pending),
        .clr_ok_o  (clr_ok),
        .sb_full_o (sb_full),
        .sb_err_o  (sb_err)
    );

    // Hazard-stall counter: counts every cycle the hazard logic itself
    // stalls ID, sticking at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz_if.fwd_id_rs = op_sel[0];
    assign hz_if.fwd_id_rt = op_sel[1];
    assign hz_if.if_stall  = hz_if.if_stall_req;
    assign hz_if.id_stall  = id_stall;
    assign hz_if.ex_stall  = ex_stall;
    assign hz_if.mem_stall = hz_if.mem_stall_req;
    assign hz_if.wb_stall  = hz_if.mem_stall_req;
    assign hz_if.sb_full   = sb_full;
    assign hz_if.sb_err    = sb_err;
    assign hz_if.stall_cnt = stall_cnt_q;

endmodule
